// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: locks onto preamble/SFD, strips preamble, SFD and FCS,
// checks CRC-32 and frame length, and streams payload bytes with end-of-frame status.
module gmii_rx_deframer #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic [7:0]  gmii_rxd,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        out_err,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [10:0] LEN_SAT     = 11'h7FF;
    localparam logic [10:0] HOLD_BYTES  = 11'd5;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     crc_q, crc_d;
    logic [10:0]     len_q, len_d;
    logic            err_q, err_d;
    logic [4:0][7:0] dly_q, dly_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            oerr_q, oerr_d;
    logic [15:0]     ok_q, ok_d;
    logic [15:0]     bad_q, bad_d;
    logic [31:0]     len32;
    logic            frame_bad;
    logic            enter_data;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign len32     = {21'd0, len_q};
    assign frame_bad = (crc_q != CRC_RESIDUE) | err_q | (len32 < MIN_LEN) | (len32 > MAX_LEN);

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        len_d      = len_q;
        err_d      = err_q;
        dly_d      = dly_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        oerr_d     = 1'b0;
        ok_d       = ok_q;
        bad_d      = bad_q;
        enter_data = 1'b0;

        case (state_q)
            WAIT_IDLE: begin
                if (!gmii_rx_dv) state_d = IDLE;
            end
            IDLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == PRE_BYTE)      state_d = PREAMBLE;
                    else if (gmii_rxd == SFD_BYTE) enter_data = 1'b1;
                    else                           state_d = DROP;
                end
            end
            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    bad_d   = bad_q + 16'd1;
                    state_d = IDLE;
                end else if (gmii_rxd == SFD_BYTE) begin
                    enter_data = 1'b1;
                end else if (gmii_rxd != PRE_BYTE) begin
                    state_d = DROP;
                end
            end
            DATA: begin
                // The newest five bytes are held back so the FCS never reaches the output.
                if (gmii_rx_dv) begin
                    crc_d = crc_byte(crc_q, gmii_rxd);
                    if (len_q != LEN_SAT) len_d = len_q + 11'd1;
                    if (gmii_rx_er) err_d = 1'b1;
                    dly_d = {dly_q[3:0], gmii_rxd};
                    if (len_q >= HOLD_BYTES) begin
                        valid_d = 1'b1;
                        data_d  = dly_q[4];
                    end
                end else begin
                    state_d = IDLE;
                    if (len_q >= HOLD_BYTES) begin
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                        data_d  = dly_q[4];
                        oerr_d  = frame_bad;
                        if (frame_bad) bad_d = bad_q + 16'd1;
                        else           ok_d  = ok_q + 16'd1;
                    end else begin
                        bad_d = bad_q + 16'd1;
                    end
                end
            end
            DROP: begin
                if (!gmii_rx_dv) begin
                    bad_d   = bad_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase

        if (enter_data) begin
            state_d = DATA;
            crc_d   = CRC_INIT;
            len_d   = 11'd0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_IDLE;
            crc_q   <= CRC_INIT;
            len_q   <= 11'd0;
            err_q   <= 1'b0;
            dly_q   <= '0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            oerr_q  <= 1'b0;
            ok_q    <= 16'd0;
            bad_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
            err_q   <= err_d;
            dly_q   <= dly_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            oerr_q  <= oerr_d;
            ok_q    <= ok_d;
            bad_q   <= bad_d;
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign out_last   = last_q;
    assign out_err    = oerr_q;
    assign frames_ok  = ok_q;
    assign frames_bad = bad_q;
endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Bench for gmii_rx_deframer: directed and randomized GMII bursts, each predicted by a
// frame-level reference model into a beat scoreboard plus expected frame counters.
module tb_gmii_rx_deframer;
    typedef logic [7:0] byteQ_t[$];
    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic        err;
        int unsigned edgeNo;
    } beat_t;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv    = 1'b0;
    logic        er    = 1'b0;
    logic [7:0]  rxd   = 8'h00;
    logic [7:0]  outData;
    logic        outValid;
    logic        outLast;
    logic        outErr;
    logic [15:0] framesOk;
    logic [15:0] framesBad;

    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] modelOk  = 16'd0;
    logic [15:0] modelBad = 16'd0;
    beat_t       expQ[$];
    beat_t       seen;

    gmii_rx_deframer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gmii_rx_dv (dv),
        .gmii_rx_er (er),
        .gmii_rxd   (rxd),
        .out_data   (outData),
        .out_valid  (outValid),
        .out_last   (outLast),
        .out_err    (outErr),
        .frames_ok  (framesOk),
        .frames_bad (framesBad)
    );

    always #5 clk = ~clk;

    // Edge counter: value after an edge is that edge's number, used to time beats.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic logic [31:0] crc32(input byteQ_t d, input int len);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'd0, d[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic byteQ_t seqPayload(input int n);
        byteQ_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(i));
        return q;
    endfunction

    function automatic byteQ_t randPayload(input int n);
        byteQ_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic byteQ_t buildFrame(input int preLen, input byteQ_t pay);
        byteQ_t      f;
        logic [31:0] fcs;
        for (int i = 0; i < preLen; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        fcs = crc32(pay, pay.size());
        foreach (pay[i]) f.push_back(pay[i]);
        for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
        return f;
    endfunction

    // Frame-level prediction: parse the burst, decide good/bad, and list every beat with
    // the edge at which it must appear (byte k rides out with byte k+5, last beat at dv fall).
    task automatic modelBurst(input byteQ_t b, input int erIdx, input int unsigned start);
        int          n;
        int          p;
        int          cnt;
        logic [31:0] fcsRx;
        logic        bad;
        byteQ_t      data;
        beat_t       e;
        n = b.size();
        p = 0;
        while (p < n && b[p] == 8'h55) p++;
        if (p >= n || b[p] != 8'hD5) begin
            modelBad++;
            return;
        end
        cnt = n - p - 1;
        if (cnt < 5) begin
            modelBad++;
            return;
        end
        for (int i = p + 1; i < n; i++) data.push_back(b[i]);
        fcsRx = {data[cnt-1], data[cnt-2], data[cnt-3], data[cnt-4]};
        bad = (fcsRx != crc32(data, cnt - 4)) || (erIdx > p && erIdx < n) ||
              (cnt < MIN_LEN) || (cnt > MAX_LEN);
        for (int k = 0; k <= cnt - 5; k++) begin
            e.data   = data[k];
            e.last   = (k == cnt - 5);
            e.err    = bad;
            e.edgeNo = e.last ? start + n : start + p + 1 + k + 5;
            expQ.push_back(e);
        end
        if (bad) modelBad++;
        else     modelOk++;
    endtask

    task automatic driveCycle(input logic v, input logic e, input logic [7:0] d);
        dv  = v;
        er  = e;
        rxd = d;
        @(posedge clk);
        #1;
    endtask

    // One dv burst plus its gap; counters and scoreboard are checked once the frame has ended.
    task automatic applyStimulus(input byteQ_t b, input int erIdx, input int gap);
        modelBurst(b, erIdx, cyc + 1);
        foreach (b[i]) driveCycle(1'b1, (i == erIdx), b[i]);
        driveCycle(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        checkOutput("beatsDrained", expQ.size(), 0);
        checkOutput("framesOk", framesOk, modelOk);
        checkOutput("framesBad", framesBad, modelBad);
        for (int g = 1; g < gap; g++) driveCycle(1'b0, 1'b0, 8'h00);
    endtask

    // Scoreboard: every valid beat must match the head of the expected queue, on time.
    always @(negedge clk) begin
        if (rst_n) begin
            while (expQ.size() > 0 && expQ[0].edgeNo < cyc) begin
                checkOutput("missedBeat", cyc, expQ[0].edgeNo);
                void'(expQ.pop_front());
            end
            if (outValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousBeat", 32'(outValid), 32'd0);
                end else begin
                    seen = expQ.pop_front();
                    checkOutput("beatData", 32'(outData), 32'(seen.data));
                    checkOutput("beatLast", 32'(outLast), 32'(seen.last));
                    checkOutput("beatCycle", cyc, seen.edgeNo);
                    if (seen.last) checkOutput("beatErr", 32'(outErr), 32'(seen.err));
                end
            end
        end
    end

    // Directed scenarios first, then a randomized mix of frame kinds and gaps.
    initial begin
        byteQ_t      f;
        byteQ_t      ref9;
        int unsigned start;
        int          kind;
        int          pre;
        int          len;
        int          gap;
        int          erIdx;
        int          idx;
        logic [7:0]  x;
        beat_t       e;

        ref9 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        checkOutput("crcModel", crc32(ref9, 9), 32'hCBF43926);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("resetValid", 32'(outValid), 0);
        checkOutput("resetData", 32'(outData), 0);
        checkOutput("resetLast", 32'(outLast), 0);
        checkOutput("resetErr", 32'(outErr), 0);
        checkOutput("resetOk", 32'(framesOk), 0);
        checkOutput("resetBad", 32'(framesBad), 0);

        applyStimulus(buildFrame(7, seqPayload(60)), -1, 1);

        f = buildFrame(7, seqPayload(60));
        f[8 + 10] = f[8 + 10] ^ 8'h01;
        applyStimulus(f, -1, 1);

        applyStimulus(buildFrame(7, seqPayload(60)), 8 + 30, 2);

        applyStimulus(buildFrame(7, randPayload(16)), -1, 1);
        applyStimulus({8'h55, 8'h55, 8'hD5, 8'h01, 8'h02, 8'h03}, -1, 1);

        f = {8'h55, 8'h55, 8'h5A};
        for (int i = 3; i < 40; i++) f.push_back(8'($urandom));
        applyStimulus(f, -1, 1);
        applyStimulus(buildFrame(7, randPayload(60)), -1, 1);

        applyStimulus(buildFrame(7, randPayload(59)), -1, 1);
        applyStimulus(buildFrame(0, randPayload(1514)), -1, 1);
        applyStimulus(buildFrame(3, randPayload(1516)), -1, 1);

        for (int it = 0; it < 24; it++) begin
            kind  = int'($urandom_range(0, 4));
            pre   = int'($urandom_range(0, 7));
            len   = int'($urandom_range(46, 100));
            gap   = int'($urandom_range(1, 3));
            erIdx = -1;
            case (kind)
                0: f = buildFrame(pre, randPayload(len));
                1: begin
                    f = buildFrame(pre, randPayload(len));
                    idx = int'($urandom_range(pre + 1, f.size() - 1));
                    f[idx] = f[idx] ^ 8'(1 << $urandom_range(0, 7));
                end
                2: begin
                    f = buildFrame(pre, randPayload(len));
                    erIdx = int'($urandom_range(pre + 1, f.size() - 1));
                end
                3: f = buildFrame(pre, randPayload(int'($urandom_range(0, 3))));
                default: begin
                    f = {};
                    for (int i = 0; i < pre; i++) f.push_back(8'h55);
                    x = 8'($urandom);
                    if (x == 8'h55 || x == 8'hD5) x = 8'h00;
                    f.push_back(x);
                    for (int i = 0; i < len; i++) f.push_back(8'($urandom));
                end
            endcase
            applyStimulus(f, erIdx, gap);
        end

        // Reset in the middle of a frame: beats already out are kept, nothing after it.
        f = buildFrame(7, seqPayload(60));
        start = cyc + 1;
        for (int k = 0; k <= 14; k++) begin
            e.data   = f[8 + k];
            e.last   = 1'b0;
            e.err    = 1'b0;
            e.edgeNo = start + 8 + k + 5;
            expQ.push_back(e);
        end
        for (int i = 0; i < 28; i++) driveCycle(1'b1, 1'b0, f[i]);
        @(negedge clk);
        #1;
        checkOutput("preResetDrained", expQ.size(), 0);
        rst_n = 1'b0;
        dv    = 1'b1;
        rxd   = f[28];
        #1;
        checkOutput("midResetValid", 32'(outValid), 0);
        checkOutput("midResetData", 32'(outData), 0);
        checkOutput("midResetLast", 32'(outLast), 0);
        checkOutput("midResetErr", 32'(outErr), 0);
        checkOutput("midResetOk", 32'(framesOk), 0);
        checkOutput("midResetBad", 32'(framesBad), 0);
        modelOk  = 16'd0;
        modelBad = 16'd0;
        @(posedge clk);
        #1;
        for (int i = 29; i < 33; i++) driveCycle(1'b1, 1'b0, f[i]);
        rst_n = 1'b1;
        for (int i = 33; i < f.size(); i++) driveCycle(1'b1, 1'b0, f[i]);
        driveCycle(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        checkOutput("postResetDrained", expQ.size(), 0);
        checkOutput("postResetOk", 32'(framesOk), 0);
        checkOutput("postResetBad", 32'(framesBad), 0);
        applyStimulus(buildFrame(7, seqPayload(60)), -1, 2);

        checkOutput("finalDrained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
